// File: rtl/clint_bridge_pkg.sv
// clint_bridge_pkg: shared types and default address map for the
// CLINT / data-RAM request bridge (FSM states, target IDs, bases).
package clint_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TGT_CLINT = 2'd0,
        TGT_RAM   = 2'd1,
        TGT_MISS  = 2'd2
    } tgt_e;

    localparam logic [63:0] DEF_CLINT_BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] DEF_RAM_BASE   = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/clint_bridge.sv
// clint_bridge: routes one CPU request at a time to the CLINT or the
// data RAM and returns a single response; unmapped addresses get err.
// Ports: clk/resetn; req_* CPU request; resp_* CPU response;
// clint_* and ram_* target sides (read data valid one cycle after en).
module clint_bridge
    import clint_bridge_pkg::*;
#(
    parameter logic [63:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [63:0] RAM_BASE   = DEF_RAM_BASE,
    parameter int unsigned RAM_AW     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_we,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        clint_en,
    output logic [7:0]  clint_we,
    output logic [63:0] clint_addr,
    output logic [63:0] clint_wdata,
    input  logic [63:0] clint_rdata,
    output logic        ram_en,
    output logic [7:0]  ram_we,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    input  logic [63:0] ram_rdata
);

    state_e      state;
    tgt_e        tgt_q;
    logic        rd_q;
    logic [63:0] hold_rdata;
    logic        hold_err;

    tgt_e        hit;
    logic        hs;
    logic [63:0] acc_rdata;
    logic        acc_err;

    function automatic tgt_e decode(input logic [63:0] a);
        tgt_e t;
        t = TGT_MISS;
        if (a[63:16] == CLINT_BASE[63:16])
            t = TGT_CLINT;
        else if (a[63:RAM_AW] == RAM_BASE[63:RAM_AW])
            t = TGT_RAM;
        return t;
    endfunction

    // Gated by resetn so no handshake or target strobe can leak out
    // while the bridge is held in reset.
    assign req_ready = resetn && (state == IDLE);
    assign hs        = req_valid && req_ready;
    assign hit       = decode(req_addr);

    assign clint_en    = hs && (hit == TGT_CLINT);
    assign clint_we    = req_we;
    assign clint_addr  = req_addr;
    assign clint_wdata = req_wdata;

    assign ram_en    = hs && (hit == TGT_RAM);
    assign ram_we    = req_we;
    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;

    // Target read data is only valid in the cycle after en, i.e. ACCESS.
    always_comb begin
        acc_rdata = '0;
        if (rd_q) begin
            case (tgt_q)
                TGT_CLINT: acc_rdata = clint_rdata;
                TGT_RAM:   acc_rdata = ram_rdata;
                default:   acc_rdata = '0;
            endcase
        end
    end

    assign acc_err = (tgt_q == TGT_MISS);

    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state)
            ACCESS: begin
                resp_valid = 1'b1;
                resp_rdata = acc_rdata;
                resp_err   = acc_err;
            end
            HOLD: begin
                resp_valid = 1'b1;
                resp_rdata = hold_rdata;
                resp_err   = hold_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tgt_q      <= TGT_MISS;
            rd_q       <= 1'b0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state <= ACCESS;
                        tgt_q <= hit;
                        rd_q  <= (req_we == 8'h00);
                    end
                end
                ACCESS: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end else begin
                        // Target data vanishes after this cycle; keep a copy.
                        hold_rdata <= acc_rdata;
                        hold_err   <= acc_err;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_bridge.sv
// tb_clint_bridge: scoreboard bench for clint_bridge with simple
// CLINT and RAM stubs whose read data is valid only after en.
module tb_clint_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_we;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        clint_en;
    logic [7:0]  clint_we;
    logic [63:0] clint_addr;
    logic [63:0] clint_wdata;
    logic [63:0] clint_rdata;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   clint_n = 0;
    int   ram_n = 0;
    int   cyc = 0;

    clint_bridge dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .clint_en(clint_en), .clint_we(clint_we),
        .clint_addr(clint_addr), .clint_wdata(clint_wdata),
        .clint_rdata(clint_rdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] clint_val(input logic [63:0] a);
        if (a == 64'h0000_0000_0200_bff8)
            return 64'h1234;
        return {32'hC0DE_0000, a[31:0]};
    endfunction

    function automatic logic [63:0] ram_val(input logic [63:0] a);
        return {a[31:0], 32'h5A5A_0000} ^ 64'h0F0F;
    endfunction

    function automatic exp_t model(input logic [63:0] a,
                                   input logic [7:0] w);
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        if (a[63:16] == 48'h0000_0000_0200) begin
            if (w == 8'h00) e.rdata = clint_val(a);
        end else if (a[63:16] == 48'h0000_0000_8000) begin
            if (w == 8'h00) e.rdata = ram_val(a);
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Target stubs: read data only meaningful the cycle after en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        clint_rdata <= (clint_en && clint_we == 8'h00)
                       ? clint_val(clint_addr) : {$urandom, $urandom};
        ram_rdata <= (ram_en && ram_we == 8'h00)
                     ? ram_val(ram_addr) : {$urandom, $urandom};
    end

    always @(negedge clk) begin
        exp_t e;
        if (clint_en) clint_n++;
        if (ram_en) ram_n++;
        checks++;
        if (clint_en && ram_en) begin
            errors++;
            $display("FAIL both_en: clint_en=%b ram_en=%b, required not both",
                     clint_en, ram_en);
        end
        if (resp_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: rdata=%h err=%b, required none",
                         resp_rdata, resp_err);
            end else if (resp_ready) begin
                e = q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    errors++;
                    $display("FAIL resp: got %h/%b, required %h/%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [7:0] w,
                         input logic [63:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_wdata = d;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        resp_ready = 1'b1;
        drive(64'h0200_bff8, 8'h00, 64'h0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({clint_en, ram_en} !== 2'b00) begin
                errors++;
                $display("FAIL reset_en: got %b, required 00",
                         {clint_en, ram_en});
            end
            checks++;
            if (resp_valid !== 1'b0 || resp_err !== 1'b0
                || resp_rdata !== 64'h0) begin
                errors++;
                $display("FAIL reset_resp: got %b/%b/%h, required 0/0/0",
                         resp_valid, resp_err, resp_rdata);
            end
        end
        req_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_clint_read();
        int c0;
        c0 = clint_n;
        step();
        drive(64'h0200_bff8, 8'h00, 64'h0);
        @(negedge clk);
        checks++;
        if (clint_en !== 1'b1 || ram_en !== 1'b0
            || clint_addr !== 64'h0200_bff8) begin
            errors++;
            $display("FAIL rd_en: got %b/%b/%h, required 1/0/0200bff8",
                     clint_en, ram_en, clint_addr);
        end
        q.push_back(model(64'h0200_bff8, 8'h00));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || clint_en !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency: valid=%b en=%b, required 1/0",
                     resp_valid, clint_en);
        end
        step();
        checks++;
        if (clint_n - c0 != 1) begin
            errors++;
            $display("FAIL rd_en_count: got %0d, required 1", clint_n - c0);
        end
    endtask

    task automatic test_clint_write();
        step();
        drive(64'h0200_4000, 8'hFF, 64'h50);
        @(negedge clk);
        checks++;
        if (clint_en !== 1'b1 || clint_we !== 8'hFF
            || clint_wdata !== 64'h50) begin
            errors++;
            $display("FAIL wr_pass: got %b/%h/%h, required 1/ff/50",
                     clint_en, clint_we, clint_wdata);
        end
        q.push_back(model(64'h0200_4000, 8'hFF));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_valid: got %b, required 1", resp_valid);
        end
        step();
    endtask

    task automatic test_hold();
        int   r0;
        exp_t e;
        r0 = ram_n;
        resp_ready = 1'b0;
        step();
        drive(64'h8000_0010, 8'h00, 64'h0);
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1) begin
            errors++;
            $display("FAIL hold_en: got %b, required 1", ram_en);
        end
        e = model(64'h8000_0010, 8'h00);
        q.push_back(e);
        step();
        drive(64'h8000_0020, 8'h00, 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata
                || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_data[%0d]: got %b/%h/%b, required 1/%h/0",
                         i, resp_valid, resp_rdata, resp_err, e.rdata);
            end
            checks++;
            if (req_ready !== 1'b0 || ram_en !== 1'b0 || clint_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall[%0d]: rdy=%b en=%b%b, required 0/00",
                         i, req_ready, clint_en, ram_en);
            end
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_rdy: got %b, required 0", req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ram_en !== 1'b1) begin
            errors++;
            $display("FAIL hold_next: rdy=%b ram_en=%b, required 1/1",
                     req_ready, ram_en);
        end
        q.push_back(model(64'h8000_0020, 8'h00));
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (ram_n - r0 != 2) begin
            errors++;
            $display("FAIL hold_en_count: got %0d, required 2", ram_n - r0);
        end
    endtask

    task automatic test_miss();
        step();
        drive(64'h1000_0000, 8'h00, 64'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || clint_en !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL miss_en: rdy=%b en=%b%b, required 1/00",
                     req_ready, clint_en, ram_en);
        end
        q.push_back(model(64'h1000_0000, 8'h00));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1
            || resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL miss_resp: got %b/%b/%h, required 1/1/0",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs[7];
        logic [7:0]  wes[7];
        int          idx;
        int          last;
        logic        ec;
        logic        er;
        addrs = '{64'h0200_0000, 64'h8000_fff8, 64'h8001_0000,
                  64'h0201_0000, 64'h8000_0100, 64'h0200_bff8,
                  64'h01ff_fff8};
        wes   = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
        idx  = 0;
        last = -1;
        resp_ready = 1'b1;
        step();
        drive(addrs[0], wes[0], 64'hA5A5_0000);
        for (int t = 0; t < 40 && idx < 7; t++) begin
            @(negedge clk);
            if (req_ready) begin
                q.push_back(model(addrs[idx], wes[idx]));
                ec = (addrs[idx][63:16] == 48'h0000_0000_0200);
                er = (addrs[idx][63:16] == 48'h0000_0000_8000);
                checks++;
                if (clint_en !== ec || ram_en !== er) begin
                    errors++;
                    $display("FAIL b2b_en[%0d]: got %b%b, required %b%b",
                             idx, clint_en, ram_en, ec, er);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_gap[%0d]: got %0d, required 2",
                                 idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
                step();
                if (idx < 7)
                    drive(addrs[idx], wes[idx], 64'hA5A5_0000 + 64'(idx));
                else
                    req_valid = 1'b0;
            end else begin
                checks++;
                if (clint_en !== 1'b0 || ram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stall_en: got %b%b, required 00",
                             clint_en, ram_en);
                end
                step();
            end
        end
        checks++;
        if (idx != 7) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d handshakes, required 7", idx);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_hold();
        resp_ready = 1'b0;
        step();
        drive(64'h8000_0040, 8'h00, 64'h0);
        @(negedge clk);
        q.push_back(model(64'h8000_0040, 8'h00));
        step();
        req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_pre: got %b, required 1", resp_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0
            || resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL rst_hold_async: got %b/%b/%h, required 0/0/0",
                     resp_valid, resp_err, resp_rdata);
        end
        q.delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold_after[%0d]: rdy=%b valid=%b, required 1/0",
                         i, req_ready, resp_valid);
            end
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_addr   = '0;
        req_we     = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        resetn     = 1'b0;
        test_reset();
        test_clint_read();
        test_clint_write();
        test_hold();
        test_miss();
        test_back_to_back();
        test_reset_in_hold();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
